// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the instruction memory (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_cs;
  logic [INST_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_cs,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_cs,
    output mem_read_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch-stage controller: owns the PC, reads the zero-latency instruction memory and
// assembles one- or two-word instructions into the IF/ID register.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0020,
  parameter logic [4:0]            IMM_OP_A   = 5'b11010,
  parameter logic [4:0]            IMM_OP_B   = 5'b11011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master          mem,
  output logic                  ifid_valid,
  output logic [INST_WIDTH-1:0] ifid_inst,
  output logic [INST_WIDTH-1:0] ifid_imm,
  output logic [ADDR_WIDTH-1:0] ifid_pc,
  output logic [ADDR_WIDTH-1:0] ifid_next_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic {StFetch, StImm} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [INST_WIDTH-1:0] imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] ifpc_q, ifpc_d;
  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;

  logic [4:0]            opcode;
  logic                  is_two_word;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign opcode      = mem.mem_read_data[INST_WIDTH-1 -: 5];
  assign is_two_word = (opcode == IMM_OP_A) || (opcode == IMM_OP_B);
  assign pc_inc      = pc_q + ADDR_WIDTH'(1);

  assign mem.mem_addr  = pc_q;
  assign mem.mem_read  = ~rst;
  assign mem.mem_cs    = ~rst;
  assign mem.mem_write = 1'b0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    imm_d       = imm_q;
    ifpc_d      = ifpc_q;
    next_pc_d   = next_pc_q;

    if (redirect_en) begin
      // Any half-fetched two-word instruction is dropped here.
      pc_d    = redirect_pc;
      state_d = StFetch;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d = pc_inc;
      unique case (state_q)
        StFetch: begin
          if (is_two_word) begin
            hold_inst_d = mem.mem_read_data;
            hold_pc_d   = pc_q;
            state_d     = StImm;
            valid_d     = 1'b0;
          end else begin
            inst_d    = mem.mem_read_data;
            imm_d     = '0;
            ifpc_d    = pc_q;
            next_pc_d = pc_inc;
            valid_d   = 1'b1;
          end
        end
        StImm: begin
          // The immediate word is never decoded as an opcode.
          inst_d    = hold_inst_q;
          imm_d     = mem.mem_read_data;
          ifpc_d    = hold_pc_q;
          next_pc_d = pc_inc;
          valid_d   = 1'b1;
          state_d   = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      imm_q       <= '0;
      ifpc_q      <= '0;
      next_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      imm_q       <= imm_d;
      ifpc_q      <= ifpc_d;
      next_pc_q   <= next_pc_d;
    end
  end

  assign ifid_valid   = valid_q;
  assign ifid_inst    = inst_q;
  assign ifid_imm     = imm_q;
  assign ifid_pc      = ifpc_q;
  assign ifid_next_pc = next_pc_q;
  assign pc           = pc_q;

endmodule
